// File: rtl/keypad_calc_entry.sv
// keypad_calc_entry
//   Debounces the 4x4 keypad matrix code and assembles a calculator request:
//   decimal operand A, an ALU operation, decimal operand B. The finished
//   request is offered to the ALU over a valid/ready handshake.
//
// Ports
//   clk         in   1    single clock
//   rst         in   1    synchronous, active-high reset
//   keypad      in   8    [7:4] row one-hot, [3:0] col one-hot, 8'h00 = no key
//   operand_a   out  OPW  first operand, binary
//   operand_b   out  OPW  second operand, binary
//   op_code     out  6    ALU opcode of the selected operation
//   calc_valid  out  1    request complete, held until accepted
//   calc_ready  in   1    ALU accepts the request while calc_valid=1
//   key_err     out  1    1-cycle pulse on a debounced illegal code
//   state       out  2    00 ENTER_A, 01 ENTER_B, 10 VALID
module keypad_calc_entry #(
   parameter int unsigned DIGITS   = 2,
   parameter int unsigned OPW      = 16,
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [7:0]     keypad,
   output logic [OPW-1:0] operand_a,
   output logic [OPW-1:0] operand_b,
   output logic [5:0]     op_code,
   output logic           calc_valid,
   input  logic           calc_ready,
   output logic           key_err,
   output logic [1:0]     state
);

   localparam int unsigned CW = $clog2(DEBOUNCE + 1);
   localparam int unsigned NW = $clog2(DIGITS + 1);
   localparam logic [CW-1:0] DB_MAX  = CW'(DEBOUNCE);
   localparam logic [NW-1:0] DIG_MAX = NW'(DIGITS);

   localparam logic [5:0] OP_ADD = 6'b000010;
   localparam logic [5:0] OP_SUB = 6'b010011;
   localparam logic [5:0] OP_OR  = 6'b010101;
   localparam logic [5:0] OP_AND = 6'b000000;

   typedef enum logic [1:0] {
      ENTER_A = 2'b00,
      ENTER_B = 2'b01,
      VALID   = 2'b10
   } state_t;

   state_t st, st_nxt;

   logic [7:0]     last_code;
   logic [CW-1:0]  db_cnt, cnt_nxt;
   logic           armed, armed_nxt;
   logic [NW-1:0]  na, nb, na_nxt, nb_nxt;
   logic [OPW-1:0] a_nxt, b_nxt;
   logic [5:0]     opc_nxt;
   logic           err_nxt;

   logic           legal;
   logic           is_digit, is_op, is_star, is_hash;
   logic [3:0]     digit;
   logic [5:0]     op_val;
   logic           stable, fire, do_clear;

   function automatic logic [OPW-1:0] shift_in(input logic [OPW-1:0] v, input logic [3:0] d);
      shift_in = (v * OPW'(10)) + OPW'(d);
   endfunction

   // Run-length of the current sample; a zero count marks "no history" so
   // the first sample after reset always starts a fresh run at 1.
   always_comb begin
      if ((keypad != last_code) || (db_cnt == '0))
         cnt_nxt = CW'(1);
      else if (db_cnt == DB_MAX)
         cnt_nxt = db_cnt;
      else
         cnt_nxt = db_cnt + CW'(1);
   end

   always_comb begin
      legal    = $onehot(keypad[7:4]) && $onehot(keypad[3:0]);
      is_digit = 1'b0;
      is_op    = 1'b0;
      is_star  = 1'b0;
      is_hash  = 1'b0;
      digit    = '0;
      op_val   = OP_ADD;
      case (keypad)
         8'h88: begin is_digit = 1'b1; digit = 4'd1; end
         8'h84: begin is_digit = 1'b1; digit = 4'd2; end
         8'h82: begin is_digit = 1'b1; digit = 4'd3; end
         8'h48: begin is_digit = 1'b1; digit = 4'd4; end
         8'h44: begin is_digit = 1'b1; digit = 4'd5; end
         8'h42: begin is_digit = 1'b1; digit = 4'd6; end
         8'h28: begin is_digit = 1'b1; digit = 4'd7; end
         8'h24: begin is_digit = 1'b1; digit = 4'd8; end
         8'h22: begin is_digit = 1'b1; digit = 4'd9; end
         8'h14: begin is_digit = 1'b1; digit = 4'd0; end
         8'h81: begin is_op = 1'b1; op_val = OP_ADD; end
         8'h41: begin is_op = 1'b1; op_val = OP_SUB; end
         8'h21: begin is_op = 1'b1; op_val = OP_OR;  end
         8'h11: begin is_op = 1'b1; op_val = OP_AND; end
         8'h18: is_star = 1'b1;
         8'h12: is_hash = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      st_nxt    = st;
      a_nxt     = operand_a;
      b_nxt     = operand_b;
      opc_nxt   = op_code;
      na_nxt    = na;
      nb_nxt    = nb;
      armed_nxt = armed;
      err_nxt   = 1'b0;
      do_clear  = 1'b0;

      stable = (cnt_nxt == DB_MAX);
      fire   = stable && armed && (keypad != 8'h00);

      if (stable && (keypad == 8'h00))
         armed_nxt = 1'b1;

      if (fire) begin
         armed_nxt = 1'b0;
         if (!legal) begin
            err_nxt = 1'b1;
         end else if (is_star) begin
            do_clear = 1'b1;
         end else begin
            case (st)
               ENTER_A: begin
                  if (is_digit && (na < DIG_MAX)) begin
                     a_nxt  = shift_in(operand_a, digit);
                     na_nxt = na + NW'(1);
                  end else if (is_op) begin
                     opc_nxt = op_val;
                     st_nxt  = ENTER_B;
                  end
               end
               ENTER_B: begin
                  if (is_digit && (nb < DIG_MAX)) begin
                     b_nxt  = shift_in(operand_b, digit);
                     nb_nxt = nb + NW'(1);
                  end else if (is_op) begin
                     opc_nxt = op_val;
                  end else if (is_hash) begin
                     st_nxt = VALID;
                  end
               end
               default: ;
            endcase
         end
      end

      // A handshake and a coincident '*' both end in the cleared ENTER_A
      // state, so one clear path covers either or both.
      if ((st == VALID) && calc_ready)
         do_clear = 1'b1;
      if (st != ENTER_A && st != ENTER_B && st != VALID)
         do_clear = 1'b1;

      if (do_clear) begin
         st_nxt  = ENTER_A;
         a_nxt   = '0;
         b_nxt   = '0;
         opc_nxt = OP_ADD;
         na_nxt  = '0;
         nb_nxt  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= ENTER_A;
         last_code <= '0;
         db_cnt    <= '0;
         armed     <= 1'b1;
         operand_a <= '0;
         operand_b <= '0;
         op_code   <= OP_ADD;
         na        <= '0;
         nb        <= '0;
         key_err   <= 1'b0;
      end else begin
         st        <= st_nxt;
         last_code <= keypad;
         db_cnt    <= cnt_nxt;
         armed     <= armed_nxt;
         operand_a <= a_nxt;
         operand_b <= b_nxt;
         op_code   <= opc_nxt;
         na        <= na_nxt;
         nb        <= nb_nxt;
         key_err   <= err_nxt;
      end
   end

   assign calc_valid = (st == VALID);
   assign state      = st;

endmodule

// File: tb/tb_keypad_calc_entry.sv
// tb_keypad_calc_entry
//   Self-checking bench for keypad_calc_entry (DIGITS=2, OPW=16, DEBOUNCE=4).
//   Each scenario task pushes its expected result to a queue as it drives the
//   keys, then pops it and compares once the DUT has had the edges it needs.
module tb_keypad_calc_entry;

   localparam int unsigned DB = 4;
   localparam logic [5:0] OP_ADD = 6'b000010;
   localparam logic [5:0] OP_SUB = 6'b010011;
   localparam logic [5:0] OP_OR  = 6'b010101;
   localparam logic [5:0] OP_AND = 6'b000000;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  keypad;
   logic [15:0] operand_a, operand_b;
   logic [5:0]  op_code;
   logic        calc_valid, calc_ready, key_err;
   logic [1:0]  state;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [5:0]  op;
      logic [1:0]  st;
      logic        v;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   n_run  = 0;
   int   n_fail = 0;

   keypad_calc_entry #(.DIGITS(2), .OPW(16), .DEBOUNCE(DB)) dut (
      .clk(clk), .rst(rst), .keypad(keypad),
      .operand_a(operand_a), .operand_b(operand_b), .op_code(op_code),
      .calc_valid(calc_valid), .calc_ready(calc_ready), .key_err(key_err),
      .state(state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic [7:0] code, input int unsigned n);
      keypad = code;
      repeat (n) tick();
   endtask

   task automatic press(input logic [7:0] code);
      hold(code, DB);
      hold(8'h00, DB);
   endtask

   task automatic test_reset();
      rst = 1'b1; keypad = 8'h00; calc_ready = 1'b0;
      exp_q.push_back('{a: 16'd0, b: 16'd0, op: OP_ADD, st: 2'b00, v: 1'b0, err: 1'b0});
      tick(); tick();
      rst = 1'b0;
      e = exp_q.pop_front();
      n_run++; if (operand_a !== e.a) begin n_fail++; $display("FAIL reset_a: got %0d expected %0d", operand_a, e.a); end
      n_run++; if (operand_b !== e.b) begin n_fail++; $display("FAIL reset_b: got %0d expected %0d", operand_b, e.b); end
      n_run++; if (op_code !== e.op) begin n_fail++; $display("FAIL reset_op: got %b expected %b", op_code, e.op); end
      n_run++; if (state !== e.st) begin n_fail++; $display("FAIL reset_state: got %b expected %b", state, e.st); end
      n_run++; if ({calc_valid, key_err} !== {e.v, e.err}) begin n_fail++; $display("FAIL reset_valid_err: got %b%b expected %b%b", calc_valid, key_err, e.v, e.err); end
   endtask

   task automatic test_basic_calc();
      exp_q.push_back('{a: 16'd4, b: 16'd0, op: OP_OR, st: 2'b01, v: 1'b0, err: 1'b0});
      press(8'h48); press(8'h21);
      e = exp_q.pop_front();
      n_run++; if (state !== e.st) begin n_fail++; $display("FAIL basic_enter_b: got %b expected %b", state, e.st); end
      n_run++; if (op_code !== e.op) begin n_fail++; $display("FAIL basic_op_latched: got %b expected %b", op_code, e.op); end
      exp_q.push_back('{a: 16'd4, b: 16'd7, op: OP_OR, st: 2'b10, v: 1'b1, err: 1'b0});
      press(8'h28); press(8'h12);
      e = exp_q.pop_front();
      n_run++; if (operand_a !== e.a) begin n_fail++; $display("FAIL basic_a: got %0d expected %0d", operand_a, e.a); end
      n_run++; if (operand_b !== e.b) begin n_fail++; $display("FAIL basic_b: got %0d expected %0d", operand_b, e.b); end
      n_run++; if (op_code !== e.op) begin n_fail++; $display("FAIL basic_op: got %b expected %b", op_code, e.op); end
      n_run++; if (state !== e.st) begin n_fail++; $display("FAIL basic_state: got %b expected %b", state, e.st); end
      n_run++; if (calc_valid !== e.v) begin n_fail++; $display("FAIL basic_valid: got %b expected %b", calc_valid, e.v); end
   endtask

   task automatic test_valid_hold();
      calc_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back('{a: 16'd4, b: 16'd7, op: OP_OR, st: 2'b10, v: 1'b1, err: 1'b0});
         tick();
         e = exp_q.pop_front();
         n_run++; if ({calc_valid, operand_a, operand_b} !== {e.v, e.a, e.b}) begin n_fail++; $display("FAIL hold_cycle%0d: got v=%b a=%0d b=%0d expected v=%b a=%0d b=%0d", i, calc_valid, operand_a, operand_b, e.v, e.a, e.b); end
      end
      exp_q.push_back('{a: 16'd0, b: 16'd0, op: OP_ADD, st: 2'b00, v: 1'b0, err: 1'b0});
      calc_ready = 1'b1;
      tick();
      calc_ready = 1'b0;
      e = exp_q.pop_front();
      n_run++; if (state !== e.st) begin n_fail++; $display("FAIL accept_state: got %b expected %b", state, e.st); end
      n_run++; if ({operand_a, operand_b} !== {e.a, e.b}) begin n_fail++; $display("FAIL accept_clear: got a=%0d b=%0d expected a=%0d b=%0d", operand_a, operand_b, e.a, e.b); end
      n_run++; if (calc_valid !== e.v) begin n_fail++; $display("FAIL accept_valid: got %b expected %b", calc_valid, e.v); end
   endtask

   task automatic test_debounce();
      exp_q.push_back('{a: 16'd0, b: 16'd0, op: OP_ADD, st: 2'b00, v: 1'b0, err: 1'b0});
      hold(8'h44, DB - 1);
      e = exp_q.pop_front();
      n_run++; if (operand_a !== e.a) begin n_fail++; $display("FAIL db_short_press: got %0d expected %0d", operand_a, e.a); end
      hold(8'h00, DB);
      exp_q.push_back('{a: 16'd0, b: 16'd0, op: OP_ADD, st: 2'b00, v: 1'b0, err: 1'b0});
      hold(8'h44, DB - 1);
      e = exp_q.pop_front();
      n_run++; if (operand_a !== e.a) begin n_fail++; $display("FAIL db_edge3: got %0d expected %0d", operand_a, e.a); end
      exp_q.push_back('{a: 16'd5, b: 16'd0, op: OP_ADD, st: 2'b00, v: 1'b0, err: 1'b0});
      tick();
      e = exp_q.pop_front();
      n_run++; if (operand_a !== e.a) begin n_fail++; $display("FAIL db_edge4: got %0d expected %0d", operand_a, e.a); end
      exp_q.push_back('{a: 16'd5, b: 16'd0, op: OP_ADD, st: 2'b00, v: 1'b0, err: 1'b0});
      hold(8'h44, 16);
      e = exp_q.pop_front();
      n_run++; if (operand_a !== e.a) begin n_fail++; $display("FAIL db_long_hold: got %0d expected %0d", operand_a, e.a); end
      hold(8'h00, DB);
      exp_q.push_back('{a: 16'd0, b: 16'd0, op: OP_ADD, st: 2'b00, v: 1'b0, err: 1'b0});
      press(8'h18);
      e = exp_q.pop_front();
      n_run++; if (operand_a !== e.a) begin n_fail++; $display("FAIL db_star_clear: got %0d expected %0d", operand_a, e.a); end
   endtask

   task automatic test_digit_limit();
      exp_q.push_back('{a: 16'd12, b: 16'd0, op: OP_ADD, st: 2'b00, v: 1'b0, err: 1'b0});
      press(8'h88); press(8'h84); press(8'h82);
      e = exp_q.pop_front();
      n_run++; if (operand_a !== e.a) begin n_fail++; $display("FAIL digits_a: got %0d expected %0d", operand_a, e.a); end
      exp_q.push_back('{a: 16'd12, b: 16'd99, op: OP_SUB, st: 2'b10, v: 1'b1, err: 1'b0});
      press(8'h41); press(8'h22); press(8'h22); press(8'h22); press(8'h12);
      e = exp_q.pop_front();
      n_run++; if (operand_b !== e.b) begin n_fail++; $display("FAIL digits_b: got %0d expected %0d", operand_b, e.b); end
      n_run++; if (op_code !== e.op) begin n_fail++; $display("FAIL digits_op: got %b expected %b", op_code, e.op); end
      n_run++; if ({state, calc_valid} !== {e.st, e.v}) begin n_fail++; $display("FAIL digits_valid: got st=%b v=%b expected st=%b v=%b", state, calc_valid, e.st, e.v); end
      calc_ready = 1'b1; tick(); calc_ready = 1'b0;
   endtask

   task automatic test_empty_b();
      exp_q.push_back('{a: 16'd3, b: 16'd0, op: OP_ADD, st: 2'b10, v: 1'b1, err: 1'b0});
      press(8'h82); press(8'h81); press(8'h12);
      e = exp_q.pop_front();
      n_run++; if ({operand_a, operand_b} !== {e.a, e.b}) begin n_fail++; $display("FAIL emptyb_operands: got a=%0d b=%0d expected a=%0d b=%0d", operand_a, operand_b, e.a, e.b); end
      n_run++; if ({state, calc_valid} !== {e.st, e.v}) begin n_fail++; $display("FAIL emptyb_valid: got st=%b v=%b expected st=%b v=%b", state, calc_valid, e.st, e.v); end
      exp_q.push_back('{a: 16'd0, b: 16'd0, op: OP_ADD, st: 2'b00, v: 1'b0, err: 1'b0});
      press(8'h18);
      e = exp_q.pop_front();
      n_run++; if ({state, calc_valid, operand_a} !== {e.st, e.v, e.a}) begin n_fail++; $display("FAIL valid_abort: got st=%b v=%b a=%0d expected st=%b v=%b a=%0d", state, calc_valid, operand_a, e.st, e.v, e.a); end
   endtask

   task automatic test_star();
      exp_q.push_back('{a: 16'd1, b: 16'd5, op: OP_ADD, st: 2'b01, v: 1'b0, err: 1'b0});
      press(8'h88); press(8'h81); press(8'h44);
      e = exp_q.pop_front();
      n_run++; if ({state, operand_a, operand_b} !== {e.st, e.a, e.b}) begin n_fail++; $display("FAIL star_setup: got st=%b a=%0d b=%0d expected st=%b a=%0d b=%0d", state, operand_a, operand_b, e.st, e.a, e.b); end
      exp_q.push_back('{a: 16'd0, b: 16'd0, op: OP_ADD, st: 2'b00, v: 1'b0, err: 1'b0});
      press(8'h18);
      e = exp_q.pop_front();
      n_run++; if ({state, operand_a, operand_b} !== {e.st, e.a, e.b}) begin n_fail++; $display("FAIL star_enter_b: got st=%b a=%0d b=%0d expected st=%b a=%0d b=%0d", state, operand_a, operand_b, e.st, e.a, e.b); end
      exp_q.push_back('{a: 16'd2, b: 16'd0, op: OP_AND, st: 2'b10, v: 1'b1, err: 1'b0});
      press(8'h84); press(8'h11); press(8'h12);
      e = exp_q.pop_front();
      n_run++; if ({state, op_code, operand_a} !== {e.st, e.op, e.a}) begin n_fail++; $display("FAIL star_valid_setup: got st=%b op=%b a=%0d expected st=%b op=%b a=%0d", state, op_code, operand_a, e.st, e.op, e.a); end
      exp_q.push_back('{a: 16'd0, b: 16'd0, op: OP_ADD, st: 2'b00, v: 1'b0, err: 1'b0});
      hold(8'h18, DB - 1);
      calc_ready = 1'b1;
      tick();
      calc_ready = 1'b0;
      e = exp_q.pop_front();
      n_run++; if ({state, calc_valid, operand_a, operand_b} !== {e.st, e.v, e.a, e.b}) begin n_fail++; $display("FAIL star_with_ready: got st=%b v=%b a=%0d b=%0d expected st=%b v=%b a=%0d b=%0d", state, calc_valid, operand_a, operand_b, e.st, e.v, e.a, e.b); end
      hold(8'h00, DB);
   endtask

   task automatic test_key_err();
      press(8'h42);
      keypad = 8'hC8;
      for (int i = 0; i < int'(DB) - 1; i++) begin
         exp_q.push_back('{a: 16'd6, b: 16'd0, op: OP_ADD, st: 2'b00, v: 1'b0, err: 1'b0});
         tick();
         e = exp_q.pop_front();
         n_run++; if (key_err !== e.err) begin n_fail++; $display("FAIL err_early%0d: got %b expected %b", i, key_err, e.err); end
      end
      exp_q.push_back('{a: 16'd6, b: 16'd0, op: OP_ADD, st: 2'b00, v: 1'b0, err: 1'b1});
      tick();
      e = exp_q.pop_front();
      n_run++; if (key_err !== e.err) begin n_fail++; $display("FAIL err_pulse: got %b expected %b", key_err, e.err); end
      n_run++; if ({operand_a, state} !== {e.a, e.st}) begin n_fail++; $display("FAIL err_no_effect: got a=%0d st=%b expected a=%0d st=%b", operand_a, state, e.a, e.st); end
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back('{a: 16'd6, b: 16'd0, op: OP_ADD, st: 2'b00, v: 1'b0, err: 1'b0});
         tick();
         e = exp_q.pop_front();
         n_run++; if (key_err !== e.err) begin n_fail++; $display("FAIL err_single%0d: got %b expected %b", i, key_err, e.err); end
      end
      exp_q.push_back('{a: 16'd6, b: 16'd0, op: OP_ADD, st: 2'b00, v: 1'b0, err: 1'b0});
      hold(8'h28, DB + 2);
      e = exp_q.pop_front();
      n_run++; if (operand_a !== e.a) begin n_fail++; $display("FAIL err_needs_release: got %0d expected %0d", operand_a, e.a); end
      hold(8'h00, DB);
      exp_q.push_back('{a: 16'd67, b: 16'd0, op: OP_ADD, st: 2'b00, v: 1'b0, err: 1'b0});
      press(8'h28);
      e = exp_q.pop_front();
      n_run++; if (operand_a !== e.a) begin n_fail++; $display("FAIL err_then_key: got %0d expected %0d", operand_a, e.a); end
   endtask

   task automatic test_reset_mid();
      press(8'h21);
      hold(8'h84, 2);
      exp_q.push_back('{a: 16'd0, b: 16'd0, op: OP_ADD, st: 2'b00, v: 1'b0, err: 1'b0});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      keypad = 8'h00;
      e = exp_q.pop_front();
      n_run++; if ({operand_a, operand_b} !== {e.a, e.b}) begin n_fail++; $display("FAIL rstmid_operands: got a=%0d b=%0d expected a=%0d b=%0d", operand_a, operand_b, e.a, e.b); end
      n_run++; if ({op_code, state, calc_valid, key_err} !== {e.op, e.st, e.v, e.err}) begin n_fail++; $display("FAIL rstmid_ctrl: got op=%b st=%b v=%b err=%b expected op=%b st=%b v=%b err=%b", op_code, state, calc_valid, key_err, e.op, e.st, e.v, e.err); end
      exp_q.push_back('{a: 16'd5, b: 16'd0, op: OP_ADD, st: 2'b00, v: 1'b0, err: 1'b0});
      hold(8'h44, DB);
      e = exp_q.pop_front();
      n_run++; if (operand_a !== e.a) begin n_fail++; $display("FAIL rstmid_armed: got %0d expected %0d", operand_a, e.a); end
      hold(8'h00, DB);
   endtask

   initial begin
      rst = 1'b1; keypad = 8'h00; calc_ready = 1'b0;
      test_reset();
      test_basic_calc();
      test_valid_hold();
      test_debounce();
      test_digit_limit();
      test_empty_b();
      test_star();
      test_key_err();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
